mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the picorv32-style memory bus.
- Lets two requesters, e.g. CPU core 0 and core 1 or CPU and a DMA engine, share the single downstream path into the address decoder and peripherals.
- Round-robin grant, held for the whole transaction.
- A per-transaction watchdog completes stalled accesses with an error word, so a dead peripheral cannot hang a master.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style memory bus.
// Grant is held for a whole transaction, and a watchdog completes stalled accesses with ERR_DATA.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clear
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             err_set;

  // Selected-master view and completion result
  logic             owner;
  logic             sel_valid;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             done;
  logic [31:0]      done_data;

  // State, arbitration history, watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Owner mux: the bus mirrors whichever master holds the grant
  always_comb begin
    owner     = (state == BUSY1);
    sel_valid = owner ? m1_valid : m0_valid;
    sel_addr  = owner ? m1_addr  : m0_addr;
    sel_wdata = owner ? m1_wdata : m0_wdata;
    sel_wstrb = owner ? m1_wstrb : m0_wstrb;
  end

  // Next-state, downstream request and completion decode
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = '0;
    err_set        = 1'b0;
    done           = 1'b0;
    done_data      = '0;
    grant          = 2'b00;
    mem_valid      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wstrb      = '0;

    unique case (state)
      IDLE: begin
        // On a tie the master that did not finish last wins
        if (m0_valid && (!m1_valid || last_grant)) begin
          state_nxt = BUSY0;
        end else if (m1_valid) begin
          state_nxt = BUSY1;
        end
      end

      BUSY0, BUSY1: begin
        grant        = owner ? 2'b10 : 2'b01;
        mem_valid    = sel_valid;
        mem_addr     = sel_addr;
        mem_wdata    = sel_wdata;
        mem_wstrb    = sel_wstrb;
        wait_cnt_nxt = wait_cnt + CNT_W'(1);

        if (!sel_valid) begin
          // Withdrawn request: drop it quietly, history untouched
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (mem_ready) begin
          done           = 1'b1;
          done_data      = mem_rdata;
          state_nxt      = IDLE;
          last_grant_nxt = owner;
          wait_cnt_nxt   = '0;
        end else if (wait_cnt == CNT_LAST) begin
          // Watchdog expiry: complete with the error word and retract the request
          done           = 1'b1;
          done_data      = ERR_DATA;
          mem_valid      = 1'b0;
          err_set        = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = owner;
          wait_cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A reset cycle aborts the transaction without any handshake
    if (reset) begin
      done      = 1'b0;
      done_data = '0;
      mem_valid = 1'b0;
      err_set   = 1'b0;
    end
  end

  // Route the completion pulse back to the owning master only
  always_comb begin
    m0_ready = done && !owner;
    m1_ready = done && owner;
    m0_rdata = m0_ready ? done_data : 32'h0;
    m1_rdata = m1_ready ? done_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;
  logic        timeout_err;
  logic        err_clear;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0; err_clear = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_m0_ready", 32'(m0_ready), 32'h0);

    // Single read with two wait cycles
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
    #1;
    chk("rd_idle_mem_valid", 32'(mem_valid), 32'h0);
    cyc();
    #1;
    chk("rd_mem_valid", 32'(mem_valid), 32'h1);
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_mem_addr", mem_addr, 32'h0000_0100);
    chk("rd_wait_m0_ready", 32'(m0_ready), 32'h0);
    cyc();
    #1;
    chk("rd_wait2_m0_ready", 32'(m0_ready), 32'h0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rd_m0_ready", 32'(m0_ready), 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_rdata", m1_rdata, 32'h0);
    cyc();
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rd_after_ready", 32'(m0_ready), 32'h0);
    chk("rd_after_rdata", m0_rdata, 32'h0);
    chk("rd_after_grant", 32'(grant), 32'h0);

    // Tie after reset: m0, then m1, then m0 again
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0000_0200;
    m1_valid = 1'b1; m1_addr = 32'h0000_0300;
    cyc();
    #1;
    chk("tie1_grant", 32'(grant), 32'h1);
    chk("tie1_mem_addr", mem_addr, 32'h0000_0200);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0000_00AA;
    #1;
    chk("tie1_m0_ready", 32'(m0_ready), 32'h1);
    chk("tie1_m1_ready", 32'(m1_ready), 32'h0);
    cyc();
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("tie_gap_grant", 32'(grant), 32'h0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0000_00BB;
    #1;
    chk("tie2_grant", 32'(grant), 32'h2);
    chk("tie2_mem_addr", mem_addr, 32'h0000_0300);
    chk("tie2_m1_rdata", m1_rdata, 32'h0000_00BB);
    chk("tie2_m0_ready", 32'(m0_ready), 32'h0);
    cyc();
    m0_valid = 1'b1; mem_ready = 1'b0;
    cyc();
    #1;
    chk("tie3_grant", 32'(grant), 32'h1);
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Continuous contention with an always-ready slave
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      chk("cont_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_m0_ready", 32'(m0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_m1_ready", 32'(m1_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
      cyc();
      #1;
      chk("cont_gap_grant", 32'(grant), 32'h0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;

    // Watchdog on an m1 write
    cyc();
    m1_valid = 1'b1; m1_addr = 32'hFFFF_0060; m1_wdata = 32'h0BAD_F00D; m1_wstrb = 4'hF;
    cyc();
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("to_wait_m1_ready", 32'(m1_ready), 32'h0);
      chk("to_wait_mem_valid", 32'(mem_valid), 32'h1);
      chk("to_wait_wstrb", 32'(mem_wstrb), 32'hF);
      cyc();
    end
    #1;
    chk("to_m1_ready", 32'(m1_ready), 32'h1);
    chk("to_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    chk("to_mem_valid", 32'(mem_valid), 32'h0);
    chk("to_err_before", 32'(timeout_err), 32'h0);
    cyc();
    m1_valid = 1'b0;
    #1;
    chk("to_err_set", 32'(timeout_err), 32'h1);
    chk("to_grant_idle", 32'(grant), 32'h0);
    err_clear = 1'b1;
    #1;
    chk("to_err_hold", 32'(timeout_err), 32'h1);
    cyc();
    err_clear = 1'b0;
    #1;
    chk("to_err_clear", 32'(timeout_err), 32'h0);

    // Ready on the very cycle the watchdog would expire
    m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
    cyc();
    for (int i = 1; i < 8; i++) cyc();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("co_m0_ready", 32'(m0_ready), 32'h1);
    chk("co_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("co_mem_valid", 32'(mem_valid), 32'h1);
    cyc();
    m0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("co_no_err", 32'(timeout_err), 32'h0);

    // Reset in the middle of a transaction, then a tie
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h0000_0500;
    cyc();
    #1;
    chk("mr_busy_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    #1;
    chk("mr_during_ready", 32'(m0_ready), 32'h0);
    cyc();
    reset = 1'b0; m1_valid = 1'b1; m1_addr = 32'h0000_0600;
    #1;
    chk("mr_mem_valid", 32'(mem_valid), 32'h0);
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_m0_ready", 32'(m0_ready), 32'h0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    chk("mr_tie_grant", 32'(grant), 32'h1);
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;

    // m1 withdraws; history stays at m0 so the next tie goes to m1
    cyc();
    m1_valid = 1'b1;
    cyc();
    m1_valid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("wd_mem_valid", 32'(mem_valid), 32'h0);
    chk("wd_m1_ready", 32'(m1_ready), 32'h0);
    cyc();
    mem_ready = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1;
    #1;
    chk("wd_idle_grant", 32'(grant), 32'h0);
    chk("wd_no_err", 32'(timeout_err), 32'h0);
    cyc();
    #1;
    chk("wd_tie_grant", 32'(grant), 32'h2);
    m0_valid = 1'b0; m1_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
